// File: rtl/aximm_csr_pkg.sv
// Shared register offsets, FSM state type and bit positions for the AXI-MM AIB CSR responder.
// The optional delay registers are enabled by defining AXIMM_CSR_DELAY_EN.
package aximm_csr_pkg;

  localparam logic [15:0] REG_MM_WR_CFG_ADDR     = 16'h1000;
  localparam logic [15:0] REG_MM_XFER_ADDR_ADDR  = 16'h1004;
  localparam logic [15:0] REG_MM_BUS_STS_ADDR    = 16'h1008;
  localparam logic [15:0] REG_MM_LINKUP_STS_ADDR = 16'h100C;
  localparam logic [15:0] REG_MM_RD_CFG_ADDR     = 16'h1010;
  localparam logic [15:0] REG_MM_DELAY_X_ADDR    = 16'h2000;
  localparam logic [15:0] REG_MM_DELAY_Y_ADDR    = 16'h2004;
  localparam logic [15:0] REG_MM_DELAY_Z_ADDR    = 16'h2008;

  // Capture window 0x4000-0x403F: addr[5:4] picks the beat, addr[3:2] the 32-bit slice
  localparam logic [9:0] REG_MM_CAPTURE_PAGE = 10'h100;
  localparam logic [1:0] CAP_DOUT_FIRST      = 2'd0;
  localparam logic [1:0] CAP_DOUT_LAST       = 2'd1;
  localparam logic [1:0] CAP_DIN_FIRST       = 2'd2;
  localparam logic [1:0] CAP_DIN_LAST        = 2'd3;

  localparam int BUS_STS_WR_DONE_BIT = 4;
  localparam int BUS_STS_RD_DONE_BIT = 5;

  localparam int          CFG_GO_BIT  = 2;
  localparam logic [31:0] CFG_GO_MASK = 32'h1 << CFG_GO_BIT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } csr_state_t;

  function automatic logic [31:0] slice_word(input logic [127:0] beat, input logic [1:0] idx);
    return beat[idx*32 +: 32];
  endfunction

endpackage

// File: rtl/aximm_csr_rdmux.sv
// Combinational read-data select for the CSR responder, including 128-bit capture slicing.
// Delay registers are only decoded when AXIMM_CSR_DELAY_EN is defined.
module aximm_csr_rdmux
  import aximm_csr_pkg::*;
#(
  parameter logic [15:0] BASE_HI = 16'h5000,
  parameter int          DLY_W   = 16
) (
  input  logic [31:0]      addr,
  input  logic [31:0]      wr_cfg,
  input  logic [31:0]      rd_cfg,
  input  logic [31:0]      xfer_addr,
  input  logic             wr_done,
  input  logic             rd_done,
  input  logic [3:0]       align_sts,
  input  logic [3:0]       link_sts,
`ifdef AXIMM_CSR_DELAY_EN
  input  logic [DLY_W-1:0] delay_x,
  input  logic [DLY_W-1:0] delay_y,
  input  logic [DLY_W-1:0] delay_z,
`endif
  input  logic [127:0]     dout_first,
  input  logic [127:0]     dout_last,
  input  logic [127:0]     din_first,
  input  logic [127:0]     din_last,
  output logic [31:0]      rdata
);

  logic [15:0] offset;
  logic        base_hit;

  assign offset   = addr[15:0];
  assign base_hit = (addr[31:16] == BASE_HI);

  // Anything not explicitly decoded, including other base pages, reads as zero
  always_comb begin
    rdata = 32'h0;
    if (base_hit) begin
      case (offset)
        REG_MM_WR_CFG_ADDR:     rdata = wr_cfg;
        REG_MM_XFER_ADDR_ADDR:  rdata = xfer_addr;
        REG_MM_BUS_STS_ADDR:    rdata = {26'b0, rd_done, wr_done, align_sts};
        REG_MM_LINKUP_STS_ADDR: rdata = {28'b0, link_sts};
        REG_MM_RD_CFG_ADDR:     rdata = rd_cfg;
`ifdef AXIMM_CSR_DELAY_EN
        REG_MM_DELAY_X_ADDR:    rdata = 32'(delay_x);
        REG_MM_DELAY_Y_ADDR:    rdata = 32'(delay_y);
        REG_MM_DELAY_Z_ADDR:    rdata = 32'(delay_z);
`endif
        default: begin
          if (offset[15:6] == REG_MM_CAPTURE_PAGE && offset[1:0] == 2'b00) begin
            case (offset[5:4])
              CAP_DOUT_FIRST: rdata = slice_word(dout_first, offset[3:2]);
              CAP_DOUT_LAST:  rdata = slice_word(dout_last,  offset[3:2]);
              CAP_DIN_FIRST:  rdata = slice_word(din_first,  offset[3:2]);
              default:        rdata = slice_word(din_last,   offset[3:2]);
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/aximm_csr_slave.sv
// AVMM control/status responder: config/delay registers, start pulses, sticky done flags.
// Define AXIMM_CSR_DELAY_EN to make DELAY_X/Y/Z writable; otherwise they are fixed constants.
module aximm_csr_slave
  import aximm_csr_pkg::*;
#(
  parameter logic [15:0] BASE_HI = 16'h5000,
  parameter int          DLY_W   = 16
) (
  input  logic             avmm_clk,
  input  logic             avmm_rst,
  input  logic             i_wren,
  input  logic             i_rden,
  input  logic [31:0]      i_wr_addr,
  input  logic [31:0]      i_wrdata,
  input  logic [3:0]       i_link_sts,
  input  logic [3:0]       i_align_sts,
  input  logic             i_wr_done,
  input  logic             i_rd_done,
  input  logic [127:0]     i_dout_first,
  input  logic [127:0]     i_dout_last,
  input  logic [127:0]     i_din_first,
  input  logic [127:0]     i_din_last,
  output logic [31:0]      o_master_readdata,
  output logic             o_master_readdatavalid,
  output logic             o_master_waitrequest,
  output logic [31:0]      o_wr_cfg,
  output logic [31:0]      o_rd_cfg,
  output logic [31:0]      o_xfer_addr,
  output logic [DLY_W-1:0] o_delay_x,
  output logic [DLY_W-1:0] o_delay_y,
  output logic [DLY_W-1:0] o_delay_z,
  output logic             o_wr_start,
  output logic             o_rd_start
);

  csr_state_t  state;
  logic        wr_done_q;
  logic        rd_done_q;
  logic [31:0] rd_word;
  logic        base_hit;

  assign base_hit = (i_wr_addr[31:16] == BASE_HI);

  aximm_csr_rdmux #(
    .BASE_HI (BASE_HI),
    .DLY_W   (DLY_W)
  ) u_rdmux (
    .addr       (i_wr_addr),
    .wr_cfg     (o_wr_cfg),
    .rd_cfg     (o_rd_cfg),
    .xfer_addr  (o_xfer_addr),
    .wr_done    (wr_done_q),
    .rd_done    (rd_done_q),
    .align_sts  (i_align_sts),
    .link_sts   (i_link_sts),
`ifdef AXIMM_CSR_DELAY_EN
    .delay_x    (o_delay_x),
    .delay_y    (o_delay_y),
    .delay_z    (o_delay_z),
`endif
    .dout_first (i_dout_first),
    .dout_last  (i_dout_last),
    .din_first  (i_din_first),
    .din_last   (i_din_last),
    .rdata      (rd_word)
  );

`ifndef AXIMM_CSR_DELAY_EN
  assign o_delay_x = DLY_W'(12);
  assign o_delay_y = DLY_W'(32);
  assign o_delay_z = DLY_W'(6000);
`endif

  // Sticky-done updates precede the write decode so a GO clear in the same cycle overrides the set
  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      state                  <= ST_IDLE;
      o_master_readdata      <= 32'h0;
      o_master_readdatavalid <= 1'b0;
      o_master_waitrequest   <= 1'b1;
      o_wr_cfg               <= 32'h0;
      o_rd_cfg               <= 32'h0;
      o_xfer_addr            <= 32'h0;
      o_wr_start             <= 1'b0;
      o_rd_start             <= 1'b0;
      wr_done_q              <= 1'b0;
      rd_done_q              <= 1'b0;
`ifdef AXIMM_CSR_DELAY_EN
      o_delay_x              <= '0;
      o_delay_y              <= '0;
      o_delay_z              <= '0;
`endif
    end else begin
      o_master_waitrequest   <= 1'b0;
      o_master_readdatavalid <= 1'b0;
      o_wr_start             <= 1'b0;
      o_rd_start             <= 1'b0;
      if (i_wr_done) wr_done_q <= 1'b1;
      if (i_rd_done) rd_done_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_wren) begin
            state <= ST_RESP;
            if (base_hit) begin
              case (i_wr_addr[15:0])
                REG_MM_WR_CFG_ADDR: begin
                  o_wr_cfg <= i_wrdata & ~CFG_GO_MASK;
                  if (i_wrdata[CFG_GO_BIT]) begin
                    o_wr_start <= 1'b1;
                    wr_done_q  <= 1'b0;
                  end
                end
                REG_MM_RD_CFG_ADDR: begin
                  o_rd_cfg <= i_wrdata & ~CFG_GO_MASK;
                  if (i_wrdata[CFG_GO_BIT]) begin
                    o_rd_start <= 1'b1;
                    rd_done_q  <= 1'b0;
                  end
                end
                REG_MM_XFER_ADDR_ADDR: o_xfer_addr <= i_wrdata;
`ifdef AXIMM_CSR_DELAY_EN
                REG_MM_DELAY_X_ADDR:   o_delay_x <= i_wrdata[DLY_W-1:0];
                REG_MM_DELAY_Y_ADDR:   o_delay_y <= i_wrdata[DLY_W-1:0];
                REG_MM_DELAY_Z_ADDR:   o_delay_z <= i_wrdata[DLY_W-1:0];
`endif
                default: ;
              endcase
            end
          end else if (i_rden) begin
            state                  <= ST_RESP;
            o_master_readdata      <= rd_word;
            o_master_readdatavalid <= 1'b1;
          end
        end
        ST_RESP: state <= ST_HOLD;
        ST_HOLD: if (!i_wren && !i_rden) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
